// File: rtl/matvec_engine.sv
// rtl/matvec_engine.sv - Y = A*X engine: serial X load, LANES parallel MACs, stalled SRAM writeback
// Coefficients come from a 1-cycle ROM; results leave one row per accepted write.
module matvec_engine #(
  parameter int XW      = 8,
  parameter int CW      = 14,
  parameter int VEC_LEN = 4,
  parameter int N_ROWS  = 8,
  parameter int LANES   = 4,
  parameter int RAM_AW  = 8,
  parameter int RAM_DW  = 32,
  parameter int SIGNED  = 0,
  localparam int ACC_W  = XW + CW + $clog2(VEC_LEN),
  localparam int G      = N_ROWS / LANES,
  localparam int CAW    = $clog2(G * VEC_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_load_en,
  input  logic                  valid_input,
  input  logic [XW-1:0]         X_load,
  output logic                  xload_done,
  input  logic                  ALU_en,
  output logic                  ALU_done,
  output logic                  busy,
  output logic [CAW-1:0]        coef_addr,
  input  logic [LANES*CW-1:0]   coef_data,
  input  logic                  ram_ready,
  output logic                  ram_we_n,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [RAM_DW-1:0]     ram_wdata
);

  localparam int JW  = $clog2(VEC_LEN + 1);
  localparam int XIW = $clog2(VEC_LEN);
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int GW  = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_COMPUTE, S_WRITE} state_t;

  state_t           state;
  logic [XW-1:0]    x [VEC_LEN];
  logic [XIW-1:0]   xcnt;
  logic [JW-1:0]    jcnt;
  logic [LW-1:0]    lane;
  logic [GW-1:0]    grp;
  logic [XW-1:0]    x_d;
  logic [ACC_W-1:0] acc [LANES];
  logic [ACC_W-1:0] prod [LANES];
  logic [ACC_W-1:0] acc_nxt [LANES];

  function automatic logic [ACC_W-1:0] ext_x(input logic [XW-1:0] v);
    logic [ACC_W-1:0] r;
    r = {ACC_W{(SIGNED != 0) && v[XW-1]}};
    r[XW-1:0] = v;
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] ext_c(input logic [CW-1:0] v);
    logic [ACC_W-1:0] r;
    r = {ACC_W{(SIGNED != 0) && v[CW-1]}};
    r[CW-1:0] = v;
    return r;
  endfunction

  function automatic logic [RAM_DW-1:0] ext_out(input logic [ACC_W-1:0] v);
    logic [RAM_DW-1:0] r;
    r = {RAM_DW{(SIGNED != 0) && v[ACC_W-1]}};
    r[ACC_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [RAM_AW-1:0] row_addr(input logic [GW-1:0] g, input logic [LW-1:0] l);
    return RAM_AW'(int'(g) * LANES + int'(l));
  endfunction

  // Operands are extended to ACC_W before multiplying, so the truncated
  // product is exact in both unsigned and two's-complement modes.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l]    = ext_x(x_d) * ext_c(coef_data[l*CW +: CW]);
      acc_nxt[l] = acc[l] + prod[l];
    end
  end

  assign busy = (state == S_LOAD) || (state == S_COMPUTE) || (state == S_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      xcnt       <= '0;
      jcnt       <= '0;
      lane       <= '0;
      grp        <= '0;
      x_d        <= '0;
      for (int i = 0; i < VEC_LEN; i++) x[i] <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
      xload_done <= 1'b0;
      ALU_done   <= 1'b0;
      coef_addr  <= '0;
      ram_we_n   <= 1'b1;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      xload_done <= 1'b0;
      ALU_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (input_load_en) begin
            state <= S_LOAD;
            xcnt  <= '0;
          end
        end
        S_LOAD: begin
          if (valid_input) begin
            x[xcnt] <= X_load;
            if (xcnt == XIW'(VEC_LEN - 1)) begin
              state      <= S_READY;
              xload_done <= 1'b1;
              xcnt       <= '0;
            end else begin
              xcnt <= xcnt + 1'b1;
            end
          end
        end
        S_READY: begin
          if (input_load_en) begin
            state <= S_LOAD;
            xcnt  <= '0;
          end else if (ALU_en) begin
            state     <= S_COMPUTE;
            grp       <= '0;
            jcnt      <= '0;
            coef_addr <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
          end
        end
        S_COMPUTE: begin
          // x_d pairs x[j] with the ROM word for address j, which returns one cycle later.
          if (jcnt != '0) begin
            for (int l = 0; l < LANES; l++) acc[l] <= acc_nxt[l];
          end
          if (jcnt < JW'(VEC_LEN)) x_d <= x[XIW'(jcnt)];
          if (jcnt < JW'(VEC_LEN - 1)) coef_addr <= coef_addr + 1'b1;
          if (jcnt == JW'(VEC_LEN)) begin
            state     <= S_WRITE;
            lane      <= '0;
            ram_we_n  <= 1'b0;
            ram_addr  <= row_addr(grp, '0);
            ram_wdata <= ext_out(acc_nxt[0]);
          end else begin
            jcnt <= jcnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (ram_ready) begin
            if (lane == LW'(LANES - 1)) begin
              ram_we_n <= 1'b1;
              if (grp == GW'(G - 1)) begin
                state    <= S_READY;
                ALU_done <= 1'b1;
              end else begin
                state     <= S_COMPUTE;
                grp       <= grp + 1'b1;
                jcnt      <= '0;
                coef_addr <= coef_addr + 1'b1;
                for (int l = 0; l < LANES; l++) acc[l] <= '0;
              end
            end else begin
              lane      <= lane + 1'b1;
              ram_addr  <= row_addr(grp, lane + 1'b1);
              ram_wdata <= ext_out(acc[lane + 1'b1]);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_engine.sv
// tb/tb_matvec_engine.sv - bench for matvec_engine, unsigned and signed instances side by side
module tb_matvec_engine;

  localparam int XW = 8;
  localparam int CW = 14;
  localparam int VL = 4;
  localparam int NR = 8;
  localparam int LN = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NA = (NR / LN) * VL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic input_load_en = 1'b0;
  logic valid_input = 1'b0;
  logic ALU_en = 1'b0;
  logic ram_ready = 1'b1;
  logic [XW-1:0] X_load = '0;

  logic xd_u, ad_u, busy_u, we_u, xd_s, ad_s, busy_s, we_s;
  logic [2:0] ca_u, ca_s;
  logic [LN*CW-1:0] cd_u = '0;
  logic [LN*CW-1:0] cd_s = '0;
  logic [AW-1:0] ra_u, ra_s;
  logic [DW-1:0] wd_u, wd_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matvec_engine u_dut (
    .clk(clk), .rst(rst), .input_load_en(input_load_en), .valid_input(valid_input),
    .X_load(X_load), .xload_done(xd_u), .ALU_en(ALU_en), .ALU_done(ad_u), .busy(busy_u),
    .coef_addr(ca_u), .coef_data(cd_u), .ram_ready(ram_ready), .ram_we_n(we_u),
    .ram_addr(ra_u), .ram_wdata(wd_u)
  );

  matvec_engine #(.SIGNED(1)) u_sdut (
    .clk(clk), .rst(rst), .input_load_en(input_load_en), .valid_input(valid_input),
    .X_load(X_load), .xload_done(xd_s), .ALU_en(ALU_en), .ALU_done(ad_s), .busy(busy_s),
    .coef_addr(ca_s), .coef_data(cd_s), .ram_ready(ram_ready), .ram_we_n(we_s),
    .ram_addr(ra_s), .ram_wdata(wd_s)
  );

  logic [XW-1:0] x_ref [VL];
  logic [CW-1:0] rom [NA][LN];

  function automatic logic [LN*CW-1:0] pack(input logic [2:0] a);
    logic [LN*CW-1:0] r;
    for (int l = 0; l < LN; l++) r[l*CW +: CW] = rom[a][l];
    return r;
  endfunction

  always @(posedge clk) begin
    cd_u <= pack(ca_u);
    cd_s <= pack(ca_s);
  end

  logic [DW-1:0] mem_u [256];
  logic [DW-1:0] mem_s [256];
  int hits_u [256];
  int wr_u = 0;
  logic mem_clr = 1'b0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_u[i]  <= 32'hDEAD_BEEF;
        mem_s[i]  <= 32'hDEAD_BEEF;
        hits_u[i] <= 0;
      end
      wr_u <= 0;
    end else begin
      if (!we_u && ram_ready) begin
        mem_u[ra_u]  <= wd_u;
        hits_u[ra_u] <= hits_u[ra_u] + 1;
        wr_u         <= wr_u + 1;
      end
      if (!we_s && ram_ready) mem_s[ra_s] <= wd_s;
    end
  end

  int xd_cnt = 0;
  always @(negedge clk) if (xd_u) xd_cnt <= xd_cnt + 1;

  // Reference: y[r] = sum_k A[r][k] * x[k], row r = g*LANES + l reading ROM word g*VL+k, lane l.
  function automatic logic [31:0] model_row(input int r, input bit sgn);
    longint s;
    int g;
    int l;
    s = 0;
    g = r / LN;
    l = r % LN;
    for (int k = 0; k < VL; k++) begin
      longint xv;
      longint cv;
      xv = longint'(x_ref[k]);
      cv = longint'(rom[g*VL+k][l]);
      if (sgn && x_ref[k][XW-1]) xv = xv - 256;
      if (sgn && rom[g*VL+k][l][CW-1]) cv = cv - 16384;
      s = s + xv * cv;
    end
    return s[31:0];
  endfunction

  task automatic clear_mem();
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
  endtask

  task automatic load_x(input int gap, input bit alu_noise);
    input_load_en = 1'b1;
    @(negedge clk);
    input_load_en = 1'b0;
    for (int k = 0; k < VL; k++) begin
      valid_input = 1'b1;
      X_load = x_ref[k];
      ALU_en = alu_noise;
      @(negedge clk);
      valid_input = 1'b0;
      X_load = $urandom_range(255, 0);
      if (k == VL - 1) ALU_en = 1'b0;
      repeat (gap) @(negedge clk);
    end
    ALU_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(output int lat, input bit stall);
    int stall_left;
    bit stalled;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    stall_left = 0;
    stalled = 0;
    h_addr = '0;
    h_data = '0;
    clear_mem();
    ALU_en = 1'b1;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) ALU_en = 1'b0;
      if (stall_left > 0) begin
        checks++;
        if (ra_u !== h_addr || wd_u !== h_data || we_u !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: addr=%0h data=%0h we_n=%b, need addr=%0h data=%0h we_n=0",
                   ra_u, wd_u, we_u, h_addr, h_data);
        end
        stall_left--;
        if (stall_left == 0) ram_ready = 1'b1;
      end else if (stall && !stalled && !we_u && wr_u == 1) begin
        stalled = 1;
        ram_ready = 1'b0;
        h_addr = ra_u;
        h_data = wd_u;
        stall_left = 3;
      end
      if (ad_u) break;
    end
    ram_ready = 1'b1;
    checks++;
    if (we_u !== 1'b1) begin
      errors++;
      $display("FAIL done_we_n: ram_we_n=%b at ALU_done, need 1", we_u);
    end
    @(negedge clk);
    checks++;
    if (ad_u !== 1'b0 || busy_u !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: ALU_done=%b busy=%b after pulse, need 0/0", ad_u, busy_u);
    end
  endtask

  task automatic check_results(input string tag);
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (mem_u[r] !== model_row(r, 0) || hits_u[r] !== 1) begin
        errors++;
        $display("FAIL %s_u row%0d: got %0h (writes=%0d), need %0h (writes=1)",
                 tag, r, mem_u[r], hits_u[r], model_row(r, 0));
      end
      checks++;
      if (mem_s[r] !== model_row(r, 1)) begin
        errors++;
        $display("FAIL %s_s row%0d: got %0h, need %0h", tag, r, mem_s[r], model_row(r, 1));
      end
    end
    checks++;
    if (wr_u !== NR) begin
      errors++;
      $display("FAIL %s_count: %0d writes, need %0d", tag, wr_u, NR);
    end
  endtask

  task automatic check_lat(input string tag, input int lat, input int need);
    checks++;
    if (lat !== need) begin
      errors++;
      $display("FAIL %s_latency: %0d cycles, need %0d", tag, lat, need);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_u !== 1'b0 || xd_u !== 1'b0 || ad_u !== 1'b0 || ca_u !== 3'd0 ||
        we_u !== 1'b1 || ra_u !== 8'd0 || wd_u !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b xd=%b ad=%b ca=%0d we_n=%b ra=%0h wd=%0h, need 0 0 0 0 1 0 0",
               busy_u, xd_u, ad_u, ca_u, we_u, ra_u, wd_u);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int xd0;
    for (int k = 0; k < VL; k++) x_ref[k] = XW'(k + 1);
    for (int a = 0; a < NA; a++) for (int l = 0; l < LN; l++) rom[a][l] = CW'(l + 1);
    xd0 = xd_cnt;
    load_x(0, 0);
    checks++;
    if (xd_cnt - xd0 !== 1) begin
      errors++;
      $display("FAIL basic_xload_done: %0d pulses, need 1", xd_cnt - xd0);
    end
    run(lat, 0);
    check_lat("basic", lat, 19);
    check_results("basic");
    checks++;
    if (mem_u[0] !== 32'd10 || mem_u[3] !== 32'd40 || mem_u[4] !== 32'd10 || mem_u[7] !== 32'd40) begin
      errors++;
      $display("FAIL basic_const: rows0,3,4,7=%0d,%0d,%0d,%0d, need 10,40,10,40",
               mem_u[0], mem_u[3], mem_u[4], mem_u[7]);
    end
  endtask

  task automatic test_full_width();
    int lat;
    for (int k = 0; k < VL; k++) x_ref[k] = 8'hFF;
    for (int a = 0; a < NA; a++) for (int l = 0; l < LN; l++) rom[a][l] = 14'h3FFF;
    load_x(1, 0);
    run(lat, 0);
    check_lat("full", lat, 19);
    check_results("full");
    checks++;
    if (mem_u[5] !== 32'h00FE_FC04) begin
      errors++;
      $display("FAIL full_const: row5=%0h, need 00fefc04", mem_u[5]);
    end
  endtask

  task automatic test_random();
    int lat;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < VL; k++) x_ref[k] = XW'($urandom);
      for (int a = 0; a < NA; a++) for (int l = 0; l < LN; l++) rom[a][l] = CW'($urandom);
      load_x($urandom_range(2, 0), 0);
      run(lat, 0);
      check_lat("random", lat, 19);
      check_results("random");
    end
  endtask

  task automatic test_stall();
    int lat;
    run(lat, 1);
    check_lat("stall", lat, 22);
    check_results("stall");
  endtask

  task automatic test_gaps();
    int lat;
    int xd0;
    int wr0;
    for (int k = 0; k < VL; k++) x_ref[k] = XW'($urandom);
    xd0 = xd_cnt;
    wr0 = wr_u;
    load_x(2, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (xd_cnt - xd0 !== 1 || busy_u !== 1'b0 || wr_u !== wr0) begin
      errors++;
      $display("FAIL gaps_load: xload_done=%0d busy=%b writes=%0d, need 1 0 %0d",
               xd_cnt - xd0, busy_u, wr_u - wr0, 0);
    end
    run(lat, 0);
    check_lat("gaps", lat, 19);
    check_results("gaps");
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    clear_mem();
    ALU_en = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) ALU_en = 1'b0;
      if (wr_u == LN && we_u && busy_u) break;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL rstmid_reach: g=1 compute not reached in %0d cycles", n);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_u !== 1'b0 || we_u !== 1'b1 || ca_u !== 3'd0 || ra_u !== 8'd0 || wd_u !== 32'd0 || ad_u !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: busy=%b we_n=%b ca=%0d ra=%0h wd=%0h ad=%b, need 0 1 0 0 0 0",
               busy_u, we_u, ca_u, ra_u, wd_u, ad_u);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (wr_u !== LN) begin
      errors++;
      $display("FAIL rstmid_writes: %0d writes after abort, need %0d", wr_u, LN);
    end
    for (int k = 0; k < VL; k++) x_ref[k] = XW'($urandom);
    load_x(0, 0);
    run(lat, 0);
    check_lat("rstmid", lat, 19);
    check_results("rstmid");
  endtask

  task automatic test_signed();
    int lat;
    for (int k = 0; k < VL; k++) x_ref[k] = 8'hFF;
    for (int a = 0; a < NA; a++) for (int l = 0; l < LN; l++) rom[a][l] = 14'd1;
    load_x(0, 0);
    for (int pass = 0; pass < 2; pass++) begin
      run(lat, 0);
      check_lat("signed", lat, 19);
      check_results("signed");
      for (int r = 0; r < NR; r++) begin
        checks++;
        if (mem_s[r] !== 32'hFFFF_FFFC) begin
          errors++;
          $display("FAIL signed_const pass%0d row%0d: got %0h, need fffffffc", pass, r, mem_s[r]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_width();
    test_random();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_signed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
